// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of a single MMIO bus.
// Each access takes exactly three cycles: IDLE (sample and grant), ACCESS (bus strobe),
// DONE (ack). A master can keep the bus across accesses by requesting with lock=1.
module mmio_arbiter #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q;
  logic   wr_q;
  logic   lock_q;
  logic   grant_id_q;
  logic   last_grant_q;

  logic              any_req;
  logic              lock_hold;
  logic              pick;
  logic              sel_wr;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wr_data;

  // Pick the winner in IDLE: a held lock beats round-robin; otherwise a tie goes to the
  // master that was not served last.
  always_comb begin
    any_req   = m0_req | m1_req;
    lock_hold = lock_q & (last_grant_q ? m1_req : m0_req);
    if (lock_hold) begin
      pick = last_grant_q;
    end else if (m0_req && m1_req) begin
      pick = ~last_grant_q;
    end else begin
      pick = m1_req;
    end
    sel_wr      = pick ? m1_wr      : m0_wr;
    sel_lock    = pick ? m1_lock    : m0_lock;
    sel_addr    = pick ? m1_addr    : m0_addr;
    sel_wr_data = pick ? m1_wr_data : m0_wr_data;
  end

  // Access FSM; all bus strobes, acks and read data are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_q         <= 1'b0;
      lock_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rd_data   <= '0;
      m1_rd_data   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StAccess;
            grant_id_q   <= pick;
            wr_q         <= sel_wr;
            lock_q       <= sel_lock;
            mmio_cs      <= 1'b1;
            mmio_wr      <= sel_wr;
            mmio_rd      <= ~sel_wr;
            mmio_addr    <= sel_addr;
            mmio_wr_data <= sel_wr_data;
          end else begin
            // Nobody requesting: a lock whose owner dropped req is released.
            lock_q <= 1'b0;
          end
        end
        StAccess: begin
          state_q      <= StDone;
          mmio_cs      <= 1'b0;
          mmio_wr      <= 1'b0;
          mmio_rd      <= 1'b0;
          mmio_addr    <= '0;
          mmio_wr_data <= '0;
          if (grant_id_q) begin
            m1_ack <= 1'b1;
            if (!wr_q) m1_rd_data <= mmio_rd_data;
          end else begin
            m0_ack <= 1'b1;
            if (!wr_q) m0_rd_data <= mmio_rd_data;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          m0_ack       <= 1'b0;
          m1_ack       <= 1'b0;
          last_grant_q <= grant_id_q;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed scoreboard bench for mmio_arbiter: stimulus pushes the expected bus operation and
// ack into queues; a negedge monitor pops and compares whenever the DUT strobes or acks.
module tb_mmio_arbiter;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data, mmio_rd_data;

  mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  // Bus model: 0xC0 reads DEADBEEF, every other address reads 0x1000_0000 | addr.
  assign mmio_rd_data = (mmio_addr == 21'h000C0) ? 32'hDEADBEEF
                                                 : (32'h1000_0000 | {11'd0, mmio_addr});

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] rd;
  } ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  bus_t be;
  ack_t ae;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cyc = -10;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_bus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_t b;
    b.wr = wr; b.addr = a; b.wdata = d;
    bus_q.push_back(b);
  endtask

  task automatic exp_ack(input logic id, input logic [DW-1:0] rd);
    ack_t x;
    x.id = id; x.rd = rd;
    ack_q.push_back(x);
  endtask

  task automatic drive(input int m, input logic req, input logic wr, input logic lock,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_req = req; m0_wr = wr; m0_lock = lock; m0_addr = a; m0_wr_data = d;
    end else begin
      m1_req = req; m1_wr = wr; m1_lock = lock; m1_addr = a; m1_wr_data = d;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe and every ack must match the head of its queue.
  always @(negedge clk) begin
    if (mmio_cs) begin
      strobe_cyc = cyc;
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got addr %0h expected no access", mmio_addr);
      end else begin
        be = bus_q.pop_front();
        check("bus_wr", 64'(mmio_wr), 64'(be.wr));
        check("bus_rd", 64'(mmio_rd), 64'(!be.wr));
        check("bus_addr", 64'(mmio_addr), 64'(be.addr));
        if (be.wr) check("bus_wdata", 64'(mmio_wr_data), 64'(be.wdata));
      end
    end else begin
      check("strobes_low", 64'({mmio_wr, mmio_rd}), 64'd0);
    end
    if (m0_ack || m1_ack) begin
      check("ack_onehot", 64'(m0_ack & m1_ack), 64'd0);
      check("ack_latency", 64'(cyc), 64'(strobe_cyc + 1));
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got m0=%0b m1=%0b expected none", m0_ack, m1_ack);
      end else begin
        ae = ack_q.pop_front();
        check("ack_id", 64'(m1_ack), 64'(ae.id));
        check("rd_data", 64'(ae.id ? m1_rd_data : m0_rd_data), 64'(ae.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    tick(3);
    check("rst_strobes", 64'({mmio_cs, mmio_wr, mmio_rd}), 64'd0);
    check("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
    check("rst_addr", 64'(mmio_addr), 64'd0);
    check("rst_wdata", 64'(mmio_wr_data), 64'd0);
    check("rst_rd_data", 64'({m0_rd_data, m1_rd_data}), 64'd0);
    reset = 1'b0;
    tick(1);

    // Single read by m0, with explicit cycle-by-cycle timing.
    exp_bus(0, 21'h000C0, '0);
    exp_ack(0, 32'hDEADBEEF);
    drive(0, 1, 0, 0, 21'h000C0, '0);
    @(negedge clk) check("rd_t_cs", 64'(mmio_cs), 64'd0);
    @(negedge clk) check("rd_t1_rd", 64'({mmio_cs, mmio_rd}), 64'b11);
    @(negedge clk) begin
      check("rd_t2_acks", 64'({m0_ack, m1_ack}), 64'b10);
      check("rd_t2_data", 64'(m0_rd_data), 64'hDEADBEEF);
    end
    tick(1);
    drive(0, 0, 0, 0, '0, '0);

    // m1 read, then m1 write which must leave m1_rd_data alone.
    exp_bus(0, 21'h00040, '0);
    exp_ack(1, 32'h1000_0040);
    drive(1, 1, 0, 0, 21'h00040, '0);
    tick(3);
    drive(1, 0, 0, 0, '0, '0);
    exp_bus(1, 21'h00080, 32'h0000_00A5);
    exp_ack(1, 32'h1000_0040);
    drive(1, 1, 1, 0, 21'h00080, 32'h0000_00A5);
    @(negedge clk);
    @(negedge clk) check("wr_t1", 64'({mmio_wr, mmio_wr_data}), {31'd0, 1'b1, 32'h0000_00A5});
    @(negedge clk) check("wr_t2_ack", 64'({m0_ack, m1_ack}), 64'b01);
    tick(1);
    drive(1, 0, 0, 0, '0, '0);
    @(negedge clk) check("wr_one_cycle", 64'({mmio_cs, mmio_wr}), 64'd0);
    check("wr_rd_kept", 64'(m1_rd_data), 64'h1000_0040);
    tick(1);

    // Tie after reset, then continuous requests: 0,1,0,1,0,1.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      exp_bus(0, 21'h00010, '0);
      exp_ack(0, 32'h1000_0010);
      exp_bus(1, 21'h00020, 32'h0000_0011);
      exp_ack(1, 32'h0);
    end
    drive(0, 1, 0, 0, 21'h00010, '0);
    drive(1, 1, 1, 0, 21'h00020, 32'h0000_0011);
    tick(18);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);

    // Lock: m0 served first so round-robin alone would favour m1 only once.
    exp_bus(0, 21'h00010, '0);
    exp_ack(0, 32'h1000_0010);
    drive(0, 1, 0, 0, 21'h00010, '0);
    tick(3);
    for (int i = 0; i < 3; i++) begin
      exp_bus(1, 21'h00030, 32'h0000_0077);
      exp_ack(1, 32'h0);
    end
    exp_bus(0, 21'h00010, '0);
    exp_ack(0, 32'h1000_0010);
    drive(1, 1, 1, 1, 21'h00030, 32'h0000_0077);
    tick(6);
    drive(1, 1, 1, 0, 21'h00030, 32'h0000_0077);
    tick(6);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);

    // Lock released by dropping req: a stale lock would hand the next tie to m1.
    exp_bus(1, 21'h00030, 32'h0000_0078);
    exp_ack(1, 32'h0);
    drive(1, 1, 1, 1, 21'h00030, 32'h0000_0078);
    tick(3);
    drive(1, 0, 0, 1, '0, '0);
    tick(1);
    exp_bus(0, 21'h00040, '0);
    exp_ack(0, 32'h1000_0040);
    exp_bus(1, 21'h00030, 32'h0000_0079);
    exp_ack(1, 32'h0);
    drive(0, 1, 0, 0, 21'h00040, '0);
    drive(1, 1, 1, 1, 21'h00030, 32'h0000_0079);
    tick(6);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);

    // Reset mid-ACCESS: aborted m1 read, then the next tie must go to m0.
    exp_bus(0, 21'h000C0, '0);
    exp_ack(0, 32'hDEADBEEF);
    drive(0, 1, 0, 0, 21'h000C0, '0);
    tick(3);
    drive(0, 0, 0, 0, '0, '0);
    exp_bus(0, 21'h00050, '0);
    drive(1, 1, 0, 0, 21'h00050, '0);
    tick(1);
    reset = 1'b1;
    @(negedge clk) check("abort_cs_before", 64'(mmio_cs), 64'd1);
    tick(1);
    reset = 1'b0;
    drive(1, 0, 0, 0, '0, '0);
    @(negedge clk) begin
      check("abort_strobes", 64'({mmio_cs, mmio_wr, mmio_rd}), 64'd0);
      check("abort_acks", 64'({m0_ack, m1_ack}), 64'd0);
    end
    tick(1);
    exp_bus(0, 21'h00010, '0);
    exp_ack(0, 32'h1000_0010);
    exp_bus(0, 21'h00020, '0);
    exp_ack(1, 32'h1000_0020);
    drive(0, 1, 0, 0, 21'h00010, '0);
    drive(1, 1, 0, 0, 21'h00020, '0);
    @(negedge clk) check("abort_no_ack", 64'({mmio_cs, m0_ack, m1_ack}), 64'd0);
    @(negedge clk) check("abort_tie_m0", 64'({mmio_cs, mmio_addr}), {42'd0, 1'b1, 21'h00010});
    repeat (5) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);

    // Dropped request: m0 pulses req only while the FSM is in DONE of an m1 access.
    exp_bus(0, 21'h00060, '0);
    exp_ack(1, 32'h1000_0060);
    drive(1, 1, 0, 0, 21'h00060, '0);
    tick(2);
    drive(0, 1, 0, 0, 21'h00070, '0);
    tick(1);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    repeat (6) @(negedge clk) check("drop_quiet", 64'({mmio_cs, m0_ack, m1_ack}), 64'd0);

    for (int i = 0; i < 20 && (bus_q.size() != 0 || ack_q.size() != 0); i++) @(posedge clk);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- ADDR_W  21  MMIO address width
- DATA_W  32  MMIO data width
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  master n requests one bus access
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  keep grant for next access (read-modify-write)
- m0_addr / m1_addr  in  ADDR_W  access address
- m0_wr_data / m1_wr_data  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rd_data / m1_rd_data  out  DATA_W  read data, valid when ack = 1
- mmio_cs, mmio_wr, mmio_rd  out  1  shared MMIO bus strobes
- mmio_addr  out  ADDR_W  shared bus address
- mmio_wr_data  out  DATA_W  shared bus write data
- mmio_rd_data  in  DATA_W  combinational read data from the bus, valid in the strobe cycle
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-005 Transitions SHALL be: IDLE->ACCESS when any req=1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-006 On IDLE->ACCESS, the block SHALL latch the granted master's wr, lock, addr and wr_data into registers, plus its index in grant_id.
REQ-007 Arbitration SHALL be round-robin: when only one req is set, that master wins; when both are set, the master not equal to last_grant wins.
REQ-008 Lock override: if the previous access had its latched lock=1 and that master's req=1 in IDLE, it SHALL win regardless of the other req.
REQ-009 In ACCESS only, the block SHALL drive mmio_cs=1, mmio_wr=latched wr, mmio_rd=~latched wr, and latched addr/wr_data; all strobes SHALL be 0 in every other state.
REQ-010 At the end of ACCESS, the block SHALL register mmio_rd_data into the granted master's rd_data. Writes SHALL leave rd_data unchanged.
REQ-011 In DONE, the block SHALL assert ack of grant_id only, for exactly one cycle, and SHALL update last_grant = grant_id.
REQ-012 Latency SHALL be fixed: req sampled in cycle t, bus strobe in t+1, ack in t+2. Maximum throughput SHALL be one access per 3 cycles.
REQ-013 Masters hold req/wr/addr/wr_data stable until ack. Changes after the IDLE sample SHALL be ignored until the next access.
REQ-014 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-015 A req deasserted before grant SHALL be dropped with no bus activity.
REQ-016 With both masters continuously requesting and lock=0, grants SHALL strictly alternate (no starvation).
REQ-017 A locked master SHALL retain the bus only while it requests with lock=1; lock=1 with req=0 SHALL release the lock.

Reset
REQ-018 While reset=1, the FSM SHALL go to IDLE; mmio_cs/wr/rd, both acks, mmio_addr, mmio_wr_data and both rd_data SHALL be 0; last_grant SHALL be 1 (so m0 wins the first tie); the latched lock SHALL be 0.
REQ-019 Reset asserted in ACCESS or DONE SHALL abort the access: no ack SHALL be issued and strobes SHALL go to 0 in the next cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single read: m0 read addr 0x000C0, mmio_rd_data=0xDEADBEEF -> mmio_rd=1 at t+1, m0_ack at t+2, m0_rd_data=0xDEADBEEF, m1_ack=0.
- Single write: m1 write addr 0x00080, data 0x000000A5 -> mmio_wr=1, mmio_wr_data=0xA5 for one cycle, m1_ack at t+2, m1_rd_data unchanged.
- Tie after reset: both req the same cycle -> m0 first, then m1. Continuous requests over 6 accesses -> grant order 0,1,0,1,0,1.
- Lock: m1 lock=1 for 3 accesses while m0 requests -> m1,m1,m1 then m0. Mid-lock release (req=0) -> m0 granted next.
- Reset mid-ACCESS: reset pulse while mmio_cs=1 -> next cycle all strobes 0, no ack, FSM in IDLE, next tie goes to m0.
- Dropped request: m0_req high one cycle while FSM in DONE of an m1 access and low by IDLE -> no further strobe, no m0_ack.
